// File: rtl/sensor_hub_pkg.sv
// Shared definitions for the sensor_hub block: FSM state encoding, request
// command codes, response codes and the response pair type.
package sensor_hub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_EVAL,
        ST_RESPOND,
        ST_LOOP_WAIT
    } state_t;

    // Request command codes
    localparam logic [7:0] CMD_STATUS    = 8'h00;
    localparam logic [7:0] CMD_TEMP      = 8'h01;
    localparam logic [7:0] CMD_HUM       = 8'h02;
    localparam logic [7:0] CMD_LOOP_TEMP = 8'h03;
    localparam logic [7:0] CMD_LOOP_HUM  = 8'h04;
    localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
    localparam logic [7:0] CMD_STOP_HUM  = 8'h06;

    // Response codes
    localparam logic [7:0] RSP_STATUS_OK = 8'h07;
    localparam logic [7:0] RSP_HUM       = 8'h08;
    localparam logic [7:0] RSP_TEMP      = 8'h09;
    localparam logic [7:0] RSP_STOPPED   = 8'h0A;
    localparam logic [7:0] RSP_FAULT     = 8'h1F;
    localparam logic [7:0] RSP_UNKNOWN   = 8'h45;
    localparam logic [7:0] RSP_NO_LOOP   = 8'hAA;
    localparam logic [7:0] RSP_BAD_ADDR  = 8'hEF;
    localparam logic [7:0] RSP_REJECT    = 8'hFF;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] value;
    } resp_t;

    function automatic resp_t mk_resp(input logic [7:0] code, input logic [7:0] value);
        resp_t r;
        r.code  = code;
        r.value = value;
        return r;
    endfunction

endpackage

// File: rtl/sensor_hub_if.sv
// Request/response bus between the UART command decoder and sensor_hub.
//   enable / request_command / request_address : one-cycle request strobe + fields
//   response_valid / response_command / response_value : one-cycle response pulse,
//     fields held until the next response
//   busy : hub is not idle
// master = command decoder side, slave = sensor_hub side.
interface sensor_hub_if;
    logic       enable;
    logic [7:0] request_command;
    logic [7:0] request_address;
    logic       response_valid;
    logic [7:0] response_command;
    logic [7:0] response_value;
    logic       busy;

    modport master (
        output enable, request_command, request_address,
        input  response_valid, response_command, response_value, busy
    );

    modport slave (
        input  enable, request_command, request_address,
        output response_valid, response_command, response_value, busy
    );
endinterface

// File: rtl/sensor_hub_frame_check.sv
// dht11_frame_check: splits a 40-bit DHT11 frame into humidity and temperature
// bytes and validates the trailing checksum byte.
//   frame       in  40  raw frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   humidity    out 8   frame[39:32]
//   temperature out 8   frame[23:16]
//   checksum_ok out 1   checksum byte equals mod-256 sum of the other four bytes
// Build option: SENSOR_HUB_CHECKSUM_EN enables the checksum comparison; when
// undefined checksum_ok is tied high and no adder is built.
module dht11_frame_check (
    input  logic [39:0] frame,
    output logic [7:0]  humidity,
    output logic [7:0]  temperature,
    output logic        checksum_ok
);
    assign humidity    = frame[39:32];
    assign temperature = frame[23:16];

`ifdef SENSOR_HUB_CHECKSUM_EN
    logic [7:0] sum;
    assign sum         = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    assign checksum_ok = (sum == frame[7:0]);
`else
    logic unused_bits;
    assign unused_bits = ^{frame[31:24], frame[15:0]};
    assign checksum_ok = 1'b1;
`endif
endmodule

// File: rtl/sensor_hub.sv
// sensor_hub: multi-channel DHT11 request/response controller. Decodes a
// (command, address) request, runs one measurement on the addressed channel
// and returns a (command, value) response. Supports timer-paced continuous
// temperature/humidity sensing and a per-measurement timeout.
//   clock, reset   single clock, asynchronous active-high reset
//   bus            sensor_hub_if.slave request/response bus
//   sensor_data    per-channel 40-bit frames, channel i at [40i+39:40i]
//   sensor_done    per-channel frame-complete level
//   sensor_error   per-channel protocol-error level
//   sensor_reset   per-channel hold-in-reset (1 = idle), at most one bit low
// Build option: SENSOR_HUB_CHECKSUM_EN adds checksum mismatch as a fault source.
module sensor_hub
    import sensor_hub_pkg::*;
#(
    parameter int NUM_SENSORS    = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int LOOP_PERIOD    = 100_000_000
) (
    input  logic                         clock,
    input  logic                         reset,
    sensor_hub_if.slave                  bus,
    input  logic [NUM_SENSORS-1:0][39:0] sensor_data,
    input  logic [NUM_SENSORS-1:0]       sensor_done,
    input  logic [NUM_SENSORS-1:0]       sensor_error,
    output logic [NUM_SENSORS-1:0]       sensor_reset
);
    localparam int TMAX = (TIMEOUT_CYCLES > LOOP_PERIOD) ? TIMEOUT_CYCLES : LOOP_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LOOP_LAST = TW'(LOOP_PERIOD - 1);

    state_t        state;
    logic [CW-1:0] ch;          // active / latched channel
    logic [7:0]    cmd_q;       // command driving the current measurement
    logic          loop_on;
    logic          loop_hum;    // continuous mode type: 1 = humidity
    logic [TW-1:0] timer;
    logic [39:0]   frame_q;
    logic          err_q;
    logic          to_q;
    logic          no_measure;  // EVAL only forwards the pending response
    resp_t         pend;

    logic [7:0] humidity;
    logic [7:0] temperature;
    logic       checksum_ok;
    logic       fault;

    dht11_frame_check u_check (
        .frame       (frame_q),
        .humidity    (humidity),
        .temperature (temperature),
        .checksum_ok (checksum_ok)
    );

    // Timeout outranks sensor_error outranks checksum; all map to the same code.
    assign fault = to_q | err_q | ~checksum_ok;

    // EVAL doubles as the one-cycle decode stage for requests that touch no
    // sensor, so every response_valid lands one cycle after EVAL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            ch                   <= '0;
            cmd_q                <= CMD_STATUS;
            loop_on              <= 1'b0;
            loop_hum             <= 1'b0;
            timer                <= '0;
            frame_q              <= '0;
            err_q                <= 1'b0;
            to_q                 <= 1'b0;
            no_measure           <= 1'b0;
            pend                 <= '0;
            sensor_reset         <= '1;
            bus.response_valid   <= 1'b0;
            bus.response_command <= 8'h00;
            bus.response_value   <= 8'h00;
            bus.busy             <= 1'b0;
        end else begin
            bus.response_valid <= 1'b0;
            // Free-running, saturating; restarted at each measurement start so
            // loop pacing is measured start-to-start.
            if (timer != '1)
                timer <= timer + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        bus.busy   <= 1'b1;
                        no_measure <= 1'b1;
                        state      <= ST_EVAL;
                        if (32'(bus.request_address) >= NUM_SENSORS) begin
                            pend <= mk_resp(RSP_BAD_ADDR, RSP_BAD_ADDR);
                        end else begin
                            case (bus.request_command)
                                CMD_STATUS, CMD_TEMP, CMD_HUM,
                                CMD_LOOP_TEMP, CMD_LOOP_HUM: begin
                                    if (bus.request_command == CMD_LOOP_TEMP ||
                                        bus.request_command == CMD_LOOP_HUM) begin
                                        loop_on  <= 1'b1;
                                        loop_hum <= (bus.request_command == CMD_LOOP_HUM);
                                    end
                                    no_measure <= 1'b0;
                                    cmd_q      <= bus.request_command;
                                    ch         <= CW'(bus.request_address);
                                    timer      <= '0;
                                    sensor_reset[CW'(bus.request_address)] <= 1'b0;
                                    state      <= ST_MEASURE;
                                end
                                CMD_STOP_TEMP, CMD_STOP_HUM:
                                    pend <= mk_resp(RSP_NO_LOOP, RSP_NO_LOOP);
                                default:
                                    pend <= mk_resp(RSP_UNKNOWN, RSP_UNKNOWN);
                            endcase
                        end
                    end
                end

                ST_MEASURE: begin
                    if (sensor_done[ch] || sensor_error[ch] || timer == TO_LAST) begin
                        frame_q      <= sensor_data[ch];
                        err_q        <= sensor_error[ch];
                        to_q         <= (timer == TO_LAST);
                        sensor_reset <= '1;
                        state        <= ST_EVAL;
                    end
                end

                ST_EVAL: begin
                    state              <= ST_RESPOND;
                    bus.response_valid <= 1'b1;
                    if (no_measure) begin
                        bus.response_command <= pend.code;
                        bus.response_value   <= pend.value;
                    end else if (fault) begin
                        bus.response_command <= RSP_FAULT;
                        bus.response_value   <= RSP_FAULT;
                    end else begin
                        case (cmd_q)
                            CMD_STATUS: begin
                                bus.response_command <= RSP_STATUS_OK;
                                bus.response_value   <= RSP_STATUS_OK;
                            end
                            CMD_TEMP, CMD_LOOP_TEMP: begin
                                bus.response_command <= RSP_TEMP;
                                bus.response_value   <= temperature;
                            end
                            CMD_HUM, CMD_LOOP_HUM: begin
                                bus.response_command <= RSP_HUM;
                                bus.response_value   <= humidity;
                            end
                            default: begin
                                bus.response_command <= RSP_UNKNOWN;
                                bus.response_value   <= RSP_UNKNOWN;
                            end
                        endcase
                    end
                end

                ST_RESPOND: begin
                    bus.busy <= loop_on;
                    state    <= loop_on ? ST_LOOP_WAIT : ST_IDLE;
                end

                ST_LOOP_WAIT: begin
                    if (bus.enable) begin
                        // Timer keeps running so a rejected request does not
                        // delay the next loop measurement.
                        no_measure <= 1'b1;
                        state      <= ST_EVAL;
                        if (bus.request_command == (loop_hum ? CMD_STOP_HUM : CMD_STOP_TEMP)) begin
                            loop_on <= 1'b0;
                            pend    <= mk_resp(RSP_STOPPED, 8'h00);
                        end else begin
                            pend    <= mk_resp(RSP_REJECT, RSP_REJECT);
                        end
                    end else if (timer >= LOOP_LAST) begin
                        no_measure       <= 1'b0;
                        timer            <= '0;
                        sensor_reset[ch] <= 1'b0;
                        state            <= ST_MEASURE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sensor_hub.md
# sensor_hub

Parametrised multi-channel successor to the single-DHT11 request/response controller. It sits between the UART command decoder and `NUM_SENSORS` DHT11 communication instances. It decodes a (command, address) request, runs one measurement on the addressed channel and returns a (command, value) response pair. It adds per-request channel addressing, a measurement timeout and timer-paced continuous sensing.

## Interface
Parameters:
- `NUM_SENSORS`, 4: number of sensor channels, 1..32.
- `TIMEOUT_CYCLES`, 50_000_000: maximum cycles from sensor release to `sensor_done` before a fault is declared.
- `LOOP_PERIOD`, 100_000_000: cycles between measurement starts in continuous mode; must be ≥ 2.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high; the reset applies on assertion and is released synchronously.
- `enable`  in  1  one-cycle request strobe.
- `request_command`  in  8  command code; sampled with `enable`.
- `request_address`  in  8  channel index; sampled with `enable`.
- `sensor_data`  in  40*NUM_SENSORS  raw frames; channel i occupies bits [40i+39:40i].
- `sensor_done`  in  NUM_SENSORS  per-channel frame-complete level.
- `sensor_error`  in  NUM_SENSORS  per-channel protocol-error level.
- `sensor_reset`  out  NUM_SENSORS  per-channel hold-in-reset; 1 = idle.
- `response_valid`  out  1  one-cycle pulse; the response fields are valid in that cycle.
- `response_command`  out  8  response code; held until the next response.
- `response_value`  out  8  response data; held until the next response.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values: `sensor_reset` all 1, `response_valid` 0, `response_command`/`response_value` 0x00, `busy` 0. The FSM goes to IDLE and the loop flag is cleared.
- FSM states:
  - IDLE: waits for a request.
  - MEASURE: one channel released; timer counting.
  - EVAL: classifies the captured frame.
  - RESPOND: pulses `response_valid`.
  - LOOP_WAIT: waits for the next continuous measurement.
- `enable` is accepted only in IDLE and LOOP_WAIT. In all other states it is ignored.
- Address check: if `request_address` ≥ `NUM_SENSORS`, go to RESPOND with 0xEF/0xEF. No sensor is touched.
- Commands accepted in IDLE:
  - 0x00: status. Response is 0x07/0x07 if healthy, 0x1F/0x1F if faulted.
  - 0x01: temperature. Response is 0x09 / temperature byte [23:16].
  - 0x02: humidity. Response is 0x08 / humidity byte [39:32].
  - 0x03: start continuous temperature. Latches loop mode and channel, then enters MEASURE.
  - 0x04: start continuous humidity. Latches loop mode and channel, then enters MEASURE.
  - 0x05, 0x06: response 0xAA/0xAA (loop not active).
  - Any other code: response 0x45/0x45.
- Fault priority: timeout, then `sensor_error`, then checksum mismatch. Any fault gives 0x1F/0x1F for commands 0x00–0x04.
- Checksum: byte[7:0] must equal the mod-256 sum of the other four bytes.
- Continuous mode: after each RESPOND the FSM enters LOOP_WAIT. When the timer reaches `LOOP_PERIOD`, it re-enters MEASURE on the latched channel.
- `enable` in LOOP_WAIT:
  - Stop code matching the loop type (0x05 for temperature, 0x06 for humidity): clears the loop; response 0x0A/0x00; then IDLE.
  - Any other code, including the mismatched stop code: response 0xFF/0xFF; the loop continues and the timer is not reset.
- A fault during continuous mode emits 0x1F/0x1F and the loop continues.

## Timing
- Cycle 0: `enable` sampled in IDLE.
- Cycle 1: addressed `sensor_reset` bit goes 0; timer cleared.
- In MEASURE, `sensor_done` or `sensor_error` on the active channel, or timer = `TIMEOUT_CYCLES`-1, ends MEASURE.
- The next cycle is EVAL, which reasserts `sensor_reset`. `response_valid` follows one cycle later.
- No-measure responses (0xEF, 0xAA, 0x45, 0x0A, 0xFF): `response_valid` at cycle 2.
- `busy` rises in cycle 1 and falls in the cycle after RESPOND if the loop is inactive. It stays high throughout continuous mode.
- Only one `sensor_reset` bit is ever 0 at a time.
- Timer width is `$clog2` of max(`TIMEOUT_CYCLES`, `LOOP_PERIOD`)+1. The timer saturates and never wraps.
- Asserting `reset` mid-measurement aborts immediately:
  - `sensor_reset` returns to all 1;
  - no response is emitted;
  - the loop is cleared.

## Configuration
- `SENSOR_HUB_CHECKSUM_EN` defined: the checksum mismatch fault is active.
- Not defined: the checksum logic is omitted; only timeout and `sensor_error` produce 0x1F.

## Structure
- Shared package `sensor_hub_pkg`:
  - FSM state enum;
  - all command codes (0x00–0x06);
  - all response codes (0x07, 0x08, 0x09, 0x0A, 0x1F, 0x45, 0xAA, 0xEF, 0xFF).
- One sub-module, `dht11_frame_check`: takes a 40-bit frame and outputs temperature, humidity and `checksum_ok`. It is instanced once, after the channel mux.

## Test plan
- Reset, then `enable` with 0x01 / address 2; channel 2 frame 0x3A00190053 with `sensor_done`. Expect `sensor_reset`=4'b1011 during measure, then response 0x09/0x19.
- Request 0x02 / address 7 with `NUM_SENSORS`=4. Expect 0xEF/0xEF at cycle 2 and `sensor_reset` never leaving 4'hF.
- `sensor_done` never asserted, `TIMEOUT_CYCLES`=100. Expect 0x1F/0x1F exactly 102 cycles after `enable`.
- 0x03 / address 0 with `LOOP_PERIOD`=1000. Expect 0x09 responses every 1000 cycles. Then 0x02 gives 0xFF/0xFF, 0x06 gives 0xFF/0xFF, and 0x05 gives 0x0A/0x00 with `busy` falling.
- Corrupt checksum byte (0x3A00190054). Expect 0x1F/0x1F with the macro defined and 0x09/0x19 without it.
- Assert `reset` mid-MEASURE. Expect `sensor_reset` all 1 and no `response_valid`; a later 0x00 request gives 0x07/0x07.
